// File: rtl/handshake_fifo_stage_if.sv
// Handshake bundle for handshake_fifo_stage.
// The slave modport is the FIFO stage's view. The master modport is the view of
// the surrounding upstream producer and downstream consumer.
interface handshake_fifo_stage_if #(
   parameter int unsigned data_width = 32,
   parameter int unsigned depth      = 4
);
   logic                    req_l;
   logic                    ack_l;
   logic [data_width-1:0]   din_l;
   logic                    req_r;
   logic                    ack_r;
   logic [data_width-1:0]   dout_r;
   logic [$clog2(depth):0]  level;

   modport slave (
      output req_l,
      input  ack_l,
      input  din_l,
      input  req_r,
      output ack_r,
      output dout_r,
      output level
   );

   modport master (
      input  req_l,
      output ack_l,
      output din_l,
      output req_r,
      input  ack_r,
      input  dout_r,
      input  level
   );
endinterface

// File: rtl/handshake_fifo_stage.sv
// Elastic buffer between an arf output port and its consumer.
// The left side consumes words from upstream using the req_l/ack_l/din_l signals.
// The right side answers each downstream req_r with a one-cycle ack_r and dout_r.
// Optional feature macro: FIFO_STATS_EN adds the peak_level and full_cycles outputs.
module handshake_fifo_stage #(
   parameter int unsigned          data_width    = 32,
   parameter int unsigned          depth         = 4,
   parameter logic [data_width-1:0] initial_value = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   handshake_fifo_stage_if.slave  bus
`ifdef FIFO_STATS_EN
   ,
   output logic [$clog2(depth):0] peak_level,
   output logic [31:0]            full_cycles
`endif
);

   localparam int unsigned     AW      = $clog2(depth);
   localparam int unsigned     PW      = AW + 1;
   localparam logic [PW-1:0]   DEPTH_L = PW'(depth);

   logic [data_width-1:0] mem [depth];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [PW-1:0]         wr_ptr_nxt, rd_ptr_nxt;
   logic [PW-1:0]         lvl;
   logic                  empty, full;
   logic                  wr_en, rd_en;
   logic                  req_l_q, req_l_nxt;
   logic                  ack_r_q;
   logic [data_width-1:0] dout_r_q;

   assign bus.req_l  = req_l_q;
   assign bus.ack_r  = ack_r_q;
   assign bus.dout_r = dout_r_q;
   assign bus.level  = lvl;

   // Occupancy flags and per-edge transfer decisions, all taken from pre-edge state
   always_comb begin
      lvl        = wr_ptr - rd_ptr;
      empty      = (lvl == '0);
      full       = (lvl == DEPTH_L);
      wr_en      = bus.ack_l & req_l_q;
      rd_en      = bus.req_r & ~ack_r_q & ~empty;
      wr_ptr_nxt = wr_en ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr_nxt = rd_en ? rd_ptr + PW'(1) : rd_ptr;
      // An outstanding request already reserves a free slot, so it may hold while the FIFO fills.
      req_l_nxt  = wr_en ? 1'b0 : (req_l_q | ~full);
   end

   // Pointers, handshake outputs and the read data register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         req_l_q  <= 1'b0;
         ack_r_q  <= 1'b0;
         dout_r_q <= initial_value;
      end else begin
         wr_ptr  <= wr_ptr_nxt;
         rd_ptr  <= rd_ptr_nxt;
         req_l_q <= req_l_nxt;
         ack_r_q <= rd_en;
         if (rd_en) begin
            dout_r_q <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

   // Storage array; reset does not clear it, because the pointers make old words unreachable
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= bus.din_l;
      end
   end

`ifdef FIFO_STATS_EN
   logic [PW-1:0] lvl_nxt;

   // Level after this edge, so the peak tracks every level that appears on the output
   always_comb begin
      lvl_nxt = wr_ptr_nxt - rd_ptr_nxt;
   end

   // Peak occupancy and a saturating count of edges sampled while full
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         peak_level  <= '0;
         full_cycles <= '0;
      end else begin
         if (lvl_nxt > peak_level) begin
            peak_level <= lvl_nxt;
         end
         if (full && (full_cycles != '1)) begin
            full_cycles <= full_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_handshake_fifo_stage.sv
// Self-checking bench for handshake_fifo_stage.
// A queue-based model tracks the FIFO and is compared with the DUT on every falling edge.
// Directed scenarios add literal expectations. Build with FIFO_STATS_EN to cover the stats outputs.
module tb_handshake_fifo_stage;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] INIT  = 32'hC0DE_0042;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   handshake_fifo_stage_if #(.data_width(DW), .depth(DEPTH)) tif();

`ifdef FIFO_STATS_EN
   logic [2:0]  peak_level;
   logic [31:0] full_cycles;
`endif

   handshake_fifo_stage #(
      .data_width   (DW),
      .depth        (DEPTH),
      .initial_value(INIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (tif.slave)
`ifdef FIFO_STATS_EN
      ,
      .peak_level (peak_level),
      .full_cycles(full_cycles)
`endif
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: contents as a queue, plus the visible handshake state
   logic [31:0] mq[$];
   bit          m_req_l;
   bit          m_ack_r;
   logic [31:0] m_dout;
   int          m_peak;
   longint      m_full;

   function automatic void model_reset();
      mq.delete();
      m_req_l = 1'b0;
      m_ack_r = 1'b0;
      m_dout  = INIT;
      m_peak  = 0;
      m_full  = 0;
   endfunction

   function automatic void model_step();
      int pre;
      bit wr;
      bit rd;
      pre = mq.size();
      wr  = tif.ack_l && m_req_l;
      rd  = tif.req_r && !m_ack_r && (pre > 0);
      if (pre == DEPTH) m_full++;
      if (rd) m_dout = mq.pop_front();
      m_ack_r = rd;
      if (wr) begin
         mq.push_back(tif.din_l);
         m_req_l = 1'b0;
      end else begin
         m_req_l = m_req_l || (pre < DEPTH);
      end
      if (mq.size() > m_peak) m_peak = mq.size();
   endfunction

   bit cmp_en = 1'b0;

   always @(negedge clk) begin
      if (cmp_en) begin
         check("req_l",  64'(tif.req_l),  64'(m_req_l));
         check("ack_r",  64'(tif.ack_r),  64'(m_ack_r));
         check("dout_r", 64'(tif.dout_r), 64'(m_dout));
         check("level",  64'(tif.level),  64'(mq.size()));
`ifdef FIFO_STATS_EN
         check("peak_level",  64'(peak_level),  64'(m_peak));
         check("full_cycles", 64'(full_cycles), 64'(m_full));
`endif
      end
   end

   task automatic step(input logic a, input logic [31:0] d, input logic r);
      tif.ack_l = a;
      tif.din_l = d;
      tif.req_r = r;
      @(posedge clk);
      if (rst) model_step();
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int k;
      int cyc;
      int sent;
      int rx;
      int maxlvl;
      int acks;
      logic [31:0] got[$];
      int          lv[$];

      tif.ack_l = 1'b0;
      tif.din_l = '0;
      tif.req_r = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_l",  64'(tif.req_l),  64'd0);
      check("rst_ack_r",  64'(tif.ack_r),  64'd0);
      check("rst_dout_r", 64'(tif.dout_r), 64'(INIT));
      check("rst_level",  64'(tif.level),  64'd0);
      rst    = 1'b1;
      cmp_en = 1'b1;

      // First edge after reset raises req_l
      step(1'b0, $urandom, 1'b0);
      check("first_req_l", 64'(tif.req_l), 64'd1);

      // Scenario 1: fill with 10,11,12,... and no consumer
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (tif.req_l) begin
            step(1'b1, 32'(10 + n), 1'b0);
            n++;
         end else begin
            step(1'b0, $urandom, 1'b0);
         end
      end
      check("s1_level_full", 64'(tif.level), 64'd4);
      check("s1_req_l_low",  64'(tif.req_l), 64'd0);
      check("s1_words_taken", 64'(n), 64'd4);
      step(1'b1, 32'h99, 1'b0);
      check("s1_spurious_level", 64'(tif.level), 64'd4);

      // Scenario 2: drain from full with req_r held
      for (int i = 0; i < 12; i++) begin
         step(1'b0, $urandom, 1'b1);
         if (tif.ack_r) begin
            got.push_back(tif.dout_r);
            lv.push_back(int'(tif.level));
         end
      end
      check("s2_ack_count", 64'(got.size()), 64'd4);
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         check("s2_dout", 64'(got[i]), 64'(10 + i));
         check("s2_level", 64'(lv[i]), 64'(3 - i));
      end

      // Scenario 3: fall-through latency on an empty FIFO
      check("s3_req_l_ready", 64'(tif.req_l), 64'd1);
      step(1'b1, 32'h0000_00A5, 1'b1);
      check("s3_no_ack_same_edge", 64'(tif.ack_r), 64'd0);
      check("s3_level_1", 64'(tif.level), 64'd1);
      step(1'b0, $urandom, 1'b1);
      check("s3_ack_next_edge", 64'(tif.ack_r), 64'd1);
      check("s3_dout_a5", 64'(tif.dout_r), 64'h0000_00A5);
      check("s3_level_0", 64'(tif.level), 64'd0);
      step(1'b0, $urandom, 1'b0);

      // Scenario 4: 5000 words with both sides running continuously
      sent = 0; rx = 0; cyc = 0; maxlvl = 0;
      while (rx < 5000 && cyc < 10100) begin
         if (tif.req_l && sent < 5000) begin
            step(1'b1, 32'(sent), 1'b1);
            sent++;
         end else begin
            step(1'b0, $urandom, 1'b1);
         end
         cyc++;
         if (int'(tif.level) > maxlvl) maxlvl = int'(tif.level);
         if (tif.ack_r) begin
            check("s4_order", 64'(tif.dout_r), 64'(rx));
            rx++;
         end
      end
      check("s4_words_received", 64'(rx), 64'd5000);
      check("s4_throughput_ok", 64'(cyc <= 10010), 64'd1);
      check("s4_level_bounded", 64'(maxlvl <= DEPTH), 64'd1);
      step(1'b0, $urandom, 1'b0);

      // Randomized traffic, including acks sent while req_l is low
      for (int i = 0; i < 3000; i++) begin
         step((tif.req_l && ($urandom_range(0, 2) != 0)) || ($urandom_range(0, 15) == 0),
              $urandom, 1'($urandom_range(0, 1)));
      end

      // Scenario 5: reset mid-stream at level 3 while ack_r is high
      for (int i = 0; i < 40 && tif.level != 0; i++) step(1'b0, $urandom, 1'b1);
      step(1'b0, $urandom, 1'b0);
      k = 0;
      for (int i = 0; i < 40 && tif.level != 3; i++) begin
         if (tif.req_l) begin
            step(1'b1, 32'h500 + 32'(k), 1'b0);
            k++;
         end else begin
            step(1'b0, $urandom, 1'b0);
         end
      end
      step(1'b0, $urandom, 1'b0);
      step(tif.req_l, 32'h5FF, 1'b1);
      check("s5_pre_level", 64'(tif.level), 64'd3);
      check("s5_pre_ack_r", 64'(tif.ack_r), 64'd1);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("s5_req_l",  64'(tif.req_l),  64'd0);
      check("s5_ack_r",  64'(tif.ack_r),  64'd0);
      check("s5_dout_r", 64'(tif.dout_r), 64'(INIT));
      check("s5_level",  64'(tif.level),  64'd0);
      tif.ack_l = 1'b0;
      tif.req_r = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, $urandom, 1'b1);
         if (tif.ack_r) acks++;
      end
      check("s5_no_stale_ack", 64'(acks), 64'd0);
      for (int i = 0; i < 12; i++) step(tif.req_l, 32'h600 + 32'(i), 1'b1);

`ifdef FIFO_STATS_EN
      // Scenario 6: statistics after a fresh fill and 7 idle cycles
      tif.ack_l = 1'b0;
      tif.req_r = 1'b0;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (tif.req_l) step(1'b1, 32'(10 + i), 1'b0);
         else           step(1'b0, $urandom, 1'b0);
      end
      step(1'b1, 32'h77, 1'b0);
      check("s6_spurious_level", 64'(tif.level), 64'd4);
      for (int i = 0; i < 7; i++) step(1'b0, $urandom, 1'b0);
      check("s6_peak_level",  64'(peak_level),  64'd4);
      check("s6_full_cycles", 64'(full_cycles), 64'd20);
`endif

      @(negedge clk);
      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
